round_robin_arbiter: RTL and testbench
======================================

ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters; the default build SHALL use 4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_i  input  NUM_REQ  request vector; bit i high = requester i wants access.
REQ-005 gnt_o  output  NUM_REQ  grant vector; one-hot or all-zero.

Function
REQ-006 gnt_o SHALL be combinational from req_i and the registered priority pointer: zero-cycle latency, grant valid in the same cycle as the request.
REQ-007 gnt_o SHALL have at most one bit set, and SHALL be 0 whenever req_i == 0.
REQ-008 A grant SHALL only go to a requester whose req_i bit is set.
REQ-009 Priority pointer ptr (log2(NUM_REQ) bits) SHALL name the highest-priority requester.
REQ-010 Search order SHALL be ptr, ptr+1, ..., NUM_REQ-1, 0, ..., ptr-1 (modulo NUM_REQ); the first set req_i bit in that order is granted.
REQ-011 On each rising clk with reset low and a grant to requester g, ptr SHALL become (g+1) mod NUM_REQ (wrap from NUM_REQ-1 to 0).
REQ-012 With no grant (req_i == 0), ptr SHALL hold its value.
REQ-013 The lone active requester SHALL be granted every cycle, regardless of ptr.
REQ-014 No handshake or hold: requests are sampled every cycle and a dropped request loses its grant immediately.
REQ-015 A continuously asserted requester SHALL be granted within NUM_REQ cycles (starvation-free).
REQ-016 Implementation: masked vector = req_i & mask(bits >= ptr); grant from the masked vector if nonzero, else from unmasked req_i, each through a lowest-index-first fixed-priority selector.

Reset
REQ-017 reset high SHALL asynchronously set ptr to 0, so requester 0 has highest priority.
REQ-018 While reset is high, gnt_o SHALL be forced to 0 and ptr SHALL not update.
REQ-019 After reset deasserts, the first grant SHALL follow order 0,1,2,3.
REQ-020 Reset asserted mid-operation SHALL discard ptr history and restart from ptr = 0.

Structure
REQ-021 A shared package SHALL hold the NUM_REQ default and the derived pointer width (clog2 NUM_REQ).
REQ-022 One sub-module, fixed_priority_arbiter (NUM_REQ-wide, lowest index wins, one-hot or zero out), SHALL be instantiated twice: for the masked and for the unmasked request vectors.
REQ-023 The top SHALL contain only the ptr register, mask generation, result select, and one-hot-to-index encode.

Verification
REQ-024 After reset, req_i=1111 held for 5 cycles -> gnt_o = 0001, 0010, 0100, 1000, 0001 (wrap).
REQ-025 req_i=0000 for 3 cycles after a grant to requester 1 -> gnt_o=0000, ptr stays 2; then req_i=0011 -> gnt_o=0001 (wrap search from 2).
REQ-026 req_i=0100 held for 4 cycles -> gnt_o=0100 every cycle.
REQ-027 After a grant to requester 2 (ptr=3), req_i=1001 -> gnt_o=1000; next cycle, same req_i -> gnt_o=0001.
REQ-028 Assert reset mid-stream with ptr=2 and req_i=1111 -> gnt_o=0000 immediately; after release -> gnt_o=0001.
REQ-029 Random req_i for 20+ cycles: each cycle gnt_o is one-hot or zero, gnt_o is a subset of req_i, and grant order matches a reference-model round robin.

Source files
------------

// File: rtl/round_robin_arbiter_pkg.sv
// rtl/round_robin_arbiter_pkg.sv - shared sizing for the round-robin arbiter
// Holds the default requester count and the derived priority-pointer width.
package round_robin_arbiter_pkg;

  localparam int NUM_REQ_DEFAULT = 4;

  // Pointer width for a given requester count; never narrower than 1 bit.
  function automatic int ptr_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  localparam int PTR_W_DEFAULT = ptr_width(NUM_REQ_DEFAULT);

endpackage

// File: rtl/round_robin_arbiter_fpa.sv
// rtl/round_robin_arbiter_fpa.sv - fixed-priority selector, lowest index wins
// Ports:
//   i_req  request vector
//   o_gnt  one-hot grant to the lowest set request bit, zero when i_req is zero
module fixed_priority_arbiter
  import round_robin_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT
) (
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_gnt
);

  // Two's-complement trick isolates the lowest set bit.
  assign o_gnt = i_req & (~i_req + NUM_REQ'(1));

endmodule

// File: rtl/round_robin_arbiter.sv
// rtl/round_robin_arbiter.sv - round-robin arbiter with combinational grant
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset; clears the pointer and blanks the grant
//   req_i  request vector, bit i = requester i wants access
//   gnt_o  one-hot or zero grant, valid in the same cycle as req_i
module round_robin_arbiter
  import round_robin_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  localparam int PTR_W = ptr_width(NUM_REQ);

  logic [PTR_W-1:0]   r_ptr;
  logic [NUM_REQ-1:0] w_mask;
  logic [NUM_REQ-1:0] w_req_masked;
  logic [NUM_REQ-1:0] w_gnt_masked;
  logic [NUM_REQ-1:0] w_gnt_unmasked;
  logic [NUM_REQ-1:0] w_gnt;
  logic [PTR_W-1:0]   w_gnt_idx;
  logic [PTR_W-1:0]   w_ptr_nxt;

  // Mask keeps requesters at or above the pointer, so the first search pass
  // runs ptr..NUM_REQ-1 and the unmasked fallback covers the wrap to 0..ptr-1.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_mask
    assign w_mask[i] = (r_ptr <= PTR_W'(i));
  end

  assign w_req_masked = req_i & w_mask;

  fixed_priority_arbiter #(.NUM_REQ(NUM_REQ)) u_fpa_masked (
    .i_req (w_req_masked),
    .o_gnt (w_gnt_masked)
  );

  fixed_priority_arbiter #(.NUM_REQ(NUM_REQ)) u_fpa_unmasked (
    .i_req (req_i),
    .o_gnt (w_gnt_unmasked)
  );

  assign w_gnt = (|w_req_masked) ? w_gnt_masked : w_gnt_unmasked;
  assign gnt_o = reset ? '0 : w_gnt;

  always_comb begin
    w_gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_gnt_idx = PTR_W'(i);
      end
    end
  end

  // Explicit wrap so non-power-of-two requester counts stay in range.
  assign w_ptr_nxt = (w_gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + PTR_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (|w_gnt) begin
      r_ptr <= w_ptr_nxt;
    end
  end

endmodule

// File: tb/tb_round_robin_arbiter.sv
// tb/tb_round_robin_arbiter.sv - scoreboard bench for round_robin_arbiter
module tb_round_robin_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req_i;
  logic [3:0] gnt_o;

  round_robin_arbiter #(.NUM_REQ(4)) dut (
    .clk   (clk),
    .reset (reset),
    .req_i (req_i),
    .gnt_o (gnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int m_ptr = 0;
  logic [7:0] exp_q[$];
  string      name_q[$];

  // Reference: walk the requesters from the pointer, modulo 4, pick the first one asking.
  task automatic step(input logic rst, input logic [3:0] r, input logic use_lit,
                      input logic [3:0] lit, input string name);
    logic [3:0] exp;
    int g;
    bit hit;
    @(negedge clk);
    reset = rst;
    req_i = r;
    hit = 0;
    g = 0;
    if (rst) begin
      m_ptr = 0;
      exp = 4'b0000;
    end else begin
      for (int k = 0; k < 4; k++) begin
        int idx;
        idx = (m_ptr + k) % 4;
        if (!hit && r[idx]) begin
          hit = 1;
          g = idx;
        end
      end
      exp = hit ? 4'(1 << g) : 4'b0000;
      if (hit) m_ptr = (g + 1) % 4;
    end
    if (use_lit) exp = lit;
    exp_q.push_back({r, exp});
    name_q.push_back(name);
  endtask

  // Monitor: the grant is combinational, so it is read once per cycle after inputs settle.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        logic [7:0] e;
        string nm;
        e = exp_q.pop_front();
        nm = name_q.pop_front();
        n_cmp++;
        if (gnt_o !== e[3:0]) begin
          n_bad++;
          $display("FAIL %s: req=%b gnt_o=%b expected=%b", nm, e[7:4], gnt_o, e[3:0]);
        end
        n_cmp++;
        if (!$onehot0(gnt_o)) begin
          n_bad++;
          $display("FAIL %s onehot: gnt_o=%b expected at most one bit", nm, gnt_o);
        end
        n_cmp++;
        if ((gnt_o & ~e[7:4]) != 4'b0000) begin
          n_bad++;
          $display("FAIL %s subset: gnt_o=%b expected subset of req=%b", nm, gnt_o, e[7:4]);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    req_i = 4'b0000;
    step(1, 4'b1111, 1, 4'b0000, "reset_hold0");
    step(1, 4'b0110, 1, 4'b0000, "reset_hold1");
    // Full request set rotates 0,1,2,3 then wraps.
    step(0, 4'b1111, 1, 4'b0001, "all_req0");
    step(0, 4'b1111, 1, 4'b0010, "all_req1");
    step(0, 4'b1111, 1, 4'b0100, "all_req2");
    step(0, 4'b1111, 1, 4'b1000, "all_req3");
    step(0, 4'b1111, 1, 4'b0001, "all_req_wrap");
    // Grant to 1 moves ptr to 2; idle cycles hold it, then the search wraps to 0.
    step(0, 4'b0010, 1, 4'b0010, "grant_r1");
    step(0, 4'b0000, 1, 4'b0000, "idle0");
    step(0, 4'b0000, 1, 4'b0000, "idle1");
    step(0, 4'b0000, 1, 4'b0000, "idle2");
    step(0, 4'b0011, 1, 4'b0001, "wrap_from_2");
    // Lone requester always wins.
    for (int i = 0; i < 4; i++) step(0, 4'b0100, 1, 4'b0100, "lone_r2");
    // ptr=3 after the grant to 2.
    step(0, 4'b1001, 1, 4'b1000, "ptr3_pick3");
    step(0, 4'b1001, 1, 4'b0001, "ptr3_then0");
    // Get ptr to 2, then reset mid-stream.
    step(0, 4'b0010, 1, 4'b0010, "pre_reset_r1");
    step(1, 4'b1111, 1, 4'b0000, "mid_reset");
    step(0, 4'b1111, 1, 4'b0001, "after_reset");
    // Random traffic against the reference, with occasional resets.
    for (int i = 0; i < 60; i++) begin
      logic rr;
      logic [3:0] rq;
      rr = ($urandom_range(0, 19) == 0);
      rq = 4'($urandom_range(0, 15));
      step(rr, rq, 0, 4'b0000, "random");
    end
    @(negedge clk);
    reset = 1'b0;
    req_i = 4'b0000;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
